instruction_fetch: RTL

Fetch stage of the single-issue MIPS pipeline.
- Owns the program counter and drives the word-aligned byte address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stall and redirect (branch/jump) requests resolved by the decode stage, flushing wrong-path instructions.

---
 rtl/instruction_fetch.sv | 89 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage of the single-issue MIPS pipeline: owns the PC, reads instruction memory
// combinationally and fills the IF/ID register, honoring decode-stage stall and redirects.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump_taken,
    input  logic [25:0] jump_index,
    output logic [29:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] pc,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    // Handshake: stall is the decode stage's "not ready"; while it is high nothing advances.
    // A redirect is a command about the IF/ID instruction, so it is only meaningful while
    // if_id_valid is high, and it overrides stall because the held instruction is wrong-path.
    typedef enum logic [1:0] {
        ACT_SEQ    = 2'd0,
        ACT_STALL  = 2'd1,
        ACT_BRANCH = 2'd2,
        ACT_JUMP   = 2'd3
    } fetch_action_e;

    fetch_action_e action;
    logic [31:0]   pc_plus4;
    logic [31:0]   branch_target;
    logic [31:0]   jump_target;
    logic [31:0]   pc_next;

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = if_id_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign jump_target   = {if_id_pc_plus4[31:28], jump_index, 2'b00};
    assign imem_address  = pc[29:0];

    always_comb begin
        action  = ACT_SEQ;
        pc_next = pc_plus4;
        if (jump_taken && if_id_valid) begin
            action  = ACT_JUMP;
            pc_next = jump_target;
        end else if (branch_taken && if_id_valid) begin
            action  = ACT_BRANCH;
            pc_next = branch_target;
        end else if (stall) begin
            action  = ACT_STALL;
            pc_next = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc                <= RESET_PC;
            if_id_instruction <= 32'd0;
            if_id_pc_plus4    <= 32'd0;
            if_id_valid       <= 1'b0;
            fetch_count       <= 32'd0;
        end else begin
            pc <= pc_next;
            case (action)
                ACT_JUMP, ACT_BRANCH: begin
                    // Flush: the instruction fetched this cycle is on the wrong path.
                    if_id_instruction <= 32'd0;
                    if_id_pc_plus4    <= 32'd0;
                    if_id_valid       <= 1'b0;
                end
                ACT_STALL: begin
                    if_id_instruction <= if_id_instruction;
                    if_id_pc_plus4    <= if_id_pc_plus4;
                    if_id_valid       <= if_id_valid;
                end
                default: begin
                    if_id_instruction <= imem_instruction;
                    if_id_pc_plus4    <= pc_plus4;
                    if_id_valid       <= 1'b1;
                    fetch_count       <= fetch_count + 32'd1;
                end
            endcase
        end
    end

endmodule
